// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: default datapath widths and the
// state encoding of the instruction/data memory port arbiter.
package mips_pkg;

  localparam int DEF_AW           = 32;
  localparam int DEF_DW           = 32;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_BUSY_IF  = 2'd1,
    ARB_BUSY_MEM = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the MEM stage.
// MEM (the older instruction) wins unless IF has been passed over
// STARVE_LIMIT times in a row. One port transaction is outstanding at a time.
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int AW           = DEF_AW,
  parameter int DW           = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  input  logic          mem_rd,
  input  logic          mem_wr,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_done,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          p_req,
  output logic          p_we,
  output logic [AW-1:0] p_addr,
  output logic [DW-1:0] p_wdata,
  input  logic          p_ack,
  input  logic [DW-1:0] p_rdata
);

  // Counter must be able to hold STARVE_LIMIT itself, since it saturates there.
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_t    state;
  arb_state_t    state_next;
  logic [SW-1:0] starve_cnt;
  logic          flush_pend;
  logic          mem_any;
  logic          starved;
  logic          mem_grant;
  logic          if_grant;

  // A simultaneous read and write is treated as a write, so only "any" matters here.
  assign mem_any = mem_rd | mem_wr;
  assign starved = (starve_cnt == STARVE_MAX);

  // Stalls follow the request/done handshake; a data access freezes fetch too.
  assign stall_mem = mem_any & ~mem_done;
  assign stall_if  = (if_req & ~if_done) | stall_mem;

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grant decision (IDLE only) and next state.
  always_comb begin
    state_next = state;
    mem_grant  = 1'b0;
    if_grant   = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (mem_any && (starve_cnt < STARVE_MAX)) begin
          mem_grant  = 1'b1;
          state_next = ARB_BUSY_MEM;
        end else if (if_req && !if_flush && (!mem_any || starved)) begin
          if_grant   = 1'b1;
          state_next = ARB_BUSY_IF;
        end
      end
      ARB_BUSY_IF: begin
        if (p_ack) begin
          state_next = ARB_IDLE;
        end
      end
      ARB_BUSY_MEM: begin
        if (p_ack) begin
          state_next = ARB_IDLE;
        end
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

  // Starvation counter: counts MEM wins while IF waits, cleared once IF is served or gone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!if_req || if_grant) begin
      starve_cnt <= '0;
    end else if (mem_grant && (starve_cnt < STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Port drive, flush tracking and registered results with their one-cycle done pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_req      <= 1'b0;
      p_we       <= 1'b0;
      p_addr     <= '0;
      p_wdata    <= '0;
      flush_pend <= 1'b0;
      if_rdata   <= '0;
      if_done    <= 1'b0;
      mem_rdata  <= '0;
      mem_done   <= 1'b0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (mem_grant) begin
            p_req   <= 1'b1;
            p_we    <= mem_wr;
            p_addr  <= mem_addr;
            p_wdata <= mem_wdata;
          end else if (if_grant) begin
            p_req      <= 1'b1;
            p_we       <= 1'b0;
            p_addr     <= if_addr;
            flush_pend <= 1'b0;
          end
        end
        ARB_BUSY_IF: begin
          if (p_ack) begin
            p_req      <= 1'b0;
            p_we       <= 1'b0;
            flush_pend <= 1'b0;
            if (!flush_pend && !if_flush) begin
              if_rdata <= p_rdata;
              if_done  <= 1'b1;
            end
          end else if (if_flush) begin
            flush_pend <= 1'b1;
          end
        end
        ARB_BUSY_MEM: begin
          if (p_ack) begin
            p_req    <= 1'b0;
            p_we     <= 1'b0;
            mem_done <= 1'b1;
            if (!p_we) begin
              mem_rdata <= p_rdata;
            end
          end
        end
        default: begin
          p_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a small port responder acks after a
// programmable wait; monitors log grant order and done-pulse order.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam byte DONE_IF  = 8'h49;
  localparam byte DONE_MEM = 8'h4D;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_done;
  logic          stall_if;
  logic          stall_mem;
  logic          p_req;
  logic          p_we;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata;
  logic          p_ack;
  logic [DW-1:0] p_rdata;

  int unsigned   port_cycle = 0;
  int unsigned   ack_wait   = 1;
  logic          stray_ack  = 1'b0;
  logic [DW-1:0] port_rdata = '0;

  int num_compared   = 0;
  int num_mismatched = 0;

  logic          preq_d = 1'b0;
  logic [AW-1:0] grant_log[$];
  byte           done_log[$];

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_done  (mem_done),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .p_req     (p_req),
    .p_we      (p_we),
    .p_addr    (p_addr),
    .p_wdata   (p_wdata),
    .p_ack     (p_ack),
    .p_rdata   (p_rdata)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Port responder: acks in port cycle number ack_wait (0 = first cycle p_req is seen).
  always @(posedge clk) begin
    if (!p_req || p_ack) port_cycle <= 0;
    else                 port_cycle <= port_cycle + 1;
  end

  assign p_ack   = (p_req && (port_cycle == ack_wait)) || stray_ack;
  assign p_rdata = port_rdata;

  // Records each new port grant (by address) and each done pulse in order.
  always @(posedge clk) begin
    if (p_req && !preq_d) grant_log.push_back(p_addr);
    preq_d <= p_req;
    if (mem_done) done_log.push_back(DONE_MEM);
    if (if_done)  done_log.push_back(DONE_IF);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_compared++;
    if (observed !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ireq, input logic [AW-1:0] iaddr,
                               input logic iflush, input logic mrd, input logic mwr,
                               input logic [AW-1:0] maddr, input logic [DW-1:0] mwdata);
    if_req    = ireq;
    if_addr   = iaddr;
    if_flush  = iflush;
    mem_rd    = mrd;
    mem_wr    = mwr;
    mem_addr  = maddr;
    mem_wdata = mwdata;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic sel_hit(input int sel);
    case (sel)
      0:       return if_done;
      1:       return mem_done;
      2:       return !p_req;
      default: return 1'b0;
    endcase
  endfunction

  task automatic waitFor(input string tag, input int sel, input int limit, output int cycles);
    cycles = 0;
    while (!sel_hit(sel) && cycles < limit) begin
      tick();
      cycles++;
    end
    if (!sel_hit(sel)) checkOutput({tag, " timeout"}, 32'd0, 32'd1);
  endtask

  function automatic logic [31:0] grant_at(input int i);
    return (grant_log.size() > i) ? grant_log[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] done_at(input int i);
    return (done_log.size() > i) ? 32'(done_log[i]) : 32'hFF;
  endfunction

  // Bounded run time in case a handshake never completes.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc;
    logic [31:0] exp_grants[6];

    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();

    // Reset state
    checkOutput("rst p_req",     32'(p_req),     32'd0);
    checkOutput("rst p_we",      32'(p_we),      32'd0);
    checkOutput("rst p_addr",    p_addr,         32'd0);
    checkOutput("rst p_wdata",   p_wdata,        32'd0);
    checkOutput("rst if_done",   32'(if_done),   32'd0);
    checkOutput("rst mem_done",  32'(mem_done),  32'd0);
    checkOutput("rst if_rdata",  if_rdata,       32'd0);
    checkOutput("rst mem_rdata", mem_rdata,      32'd0);
    checkOutput("rst stall_if",  32'(stall_if),  32'd0);
    rst = 1'b0;
    tick();

    // Lone fetch, ack in second port cycle
    grant_log.delete(); done_log.delete();
    port_rdata = 32'h8C22_0004; ack_wait = 1;
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("fetch stall_if pending", 32'(stall_if), 32'd1);
    tick();
    checkOutput("fetch p_req",   32'(p_req), 32'd1);
    checkOutput("fetch p_addr",  p_addr,     32'h40);
    checkOutput("fetch p_we",    32'(p_we),  32'd0);
    tick();
    checkOutput("fetch no early done", 32'(if_done), 32'd0);
    tick();
    checkOutput("fetch if_done",  32'(if_done),  32'd1);
    checkOutput("fetch if_rdata", if_rdata,      32'h8C22_0004);
    checkOutput("fetch stall_if released", 32'(stall_if), 32'd0);
    checkOutput("fetch p_req dropped", 32'(p_req), 32'd0);
    applyStimulus(1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("fetch done one cycle", 32'(if_done), 32'd0);
    checkOutput("fetch grant count", 32'(grant_log.size()), 32'd1);

    // Simultaneous IF and MEM write: MEM first
    grant_log.delete(); done_log.delete();
    port_rdata = 32'h1234_5678; ack_wait = 1;
    applyStimulus(1'b1, 32'h44, 1'b0, 1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF);
    #1;
    checkOutput("sim stall_mem", 32'(stall_mem), 32'd1);
    checkOutput("sim stall_if",  32'(stall_if),  32'd1);
    tick();
    checkOutput("sim mem p_req",   32'(p_req), 32'd1);
    checkOutput("sim mem p_we",    32'(p_we),  32'd1);
    checkOutput("sim mem p_addr",  p_addr,     32'h100);
    checkOutput("sim mem p_wdata", p_wdata,    32'hDEAD_BEEF);
    waitFor("sim mem_done", 1, 10, cyc);
    checkOutput("sim mem_done latency", 32'(cyc), 32'd2);
    checkOutput("sim write keeps mem_rdata", mem_rdata, 32'd0);
    checkOutput("sim no if_done yet", 32'(if_done), 32'd0);
    applyStimulus(1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("sim if p_req",  32'(p_req), 32'd1);
    checkOutput("sim if p_we",   32'(p_we),  32'd0);
    checkOutput("sim if p_addr", p_addr,     32'h44);
    waitFor("sim if_done", 0, 10, cyc);
    checkOutput("sim if_rdata", if_rdata, 32'h1234_5678);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("sim done count", 32'(done_log.size()), 32'd2);
    checkOutput("sim first done",  done_at(0), 32'(DONE_MEM));
    checkOutput("sim second done", done_at(1), 32'(DONE_IF));

    // Starvation: MEM reads held with IF waiting, fifth grant goes to IF
    grant_log.delete(); done_log.delete();
    port_rdata = 32'hA5A5_0000; ack_wait = 1;
    applyStimulus(1'b1, 32'h48, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0);
    cyc = 0;
    while (grant_log.size() < 6 && cyc < 80) begin
      tick();
      cyc++;
    end
    if (grant_log.size() < 6) checkOutput("starve grants timeout", 32'(grant_log.size()), 32'd6);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    waitFor("starve drain", 2, 10, cyc);
    tick();
    tick();
    exp_grants = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h48, 32'h200};
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("starve grant %0d", i), grant_at(i), exp_grants[i]);
    checkOutput("starve mem_rdata", mem_rdata, 32'hA5A5_0000);
    checkOutput("starve if_rdata",  if_rdata,  32'hA5A5_0000);

    // Stray ack while idle is ignored
    port_rdata = 32'hBADB_AD00;
    stray_ack = 1'b1;
    tick();
    stray_ack = 1'b0;
    checkOutput("stray if_done",   32'(if_done),  32'd0);
    checkOutput("stray mem_done",  32'(mem_done), 32'd0);
    checkOutput("stray if_rdata",  if_rdata,      32'hA5A5_0000);
    checkOutput("stray mem_rdata", mem_rdata,     32'hA5A5_0000);
    tick();

    // Flush in IDLE blocks one cycle; then minimum latency with ack in first port cycle
    grant_log.delete(); done_log.delete();
    port_rdata = 32'h0000_0C0D; ack_wait = 0;
    applyStimulus(1'b1, 32'h50, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("idle flush blocks grant", 32'(p_req), 32'd0);
    applyStimulus(1'b1, 32'h50, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("minlat p_req",  32'(p_req), 32'd1);
    checkOutput("minlat p_addr", p_addr,     32'h50);
    tick();
    checkOutput("minlat if_done",  32'(if_done), 32'd1);
    checkOutput("minlat if_rdata", if_rdata,     32'h0000_0C0D);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // Flush while the fetch is outstanding
    grant_log.delete(); done_log.delete();
    port_rdata = 32'hFFFF_0001; ack_wait = 3;
    applyStimulus(1'b1, 32'h4C, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("flush p_req", 32'(p_req), 32'd1);
    applyStimulus(1'b1, 32'h4C, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    applyStimulus(1'b1, 32'h4C, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("flush p_addr held", p_addr, 32'h4C);
    waitFor("flush ack", 2, 10, cyc);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    checkOutput("flush no if_done",    32'(done_log.size()), 32'd0);
    checkOutput("flush if_rdata kept", if_rdata,             32'h0000_0C0D);
    checkOutput("flush back to idle",  32'(p_req),           32'd0);
    checkOutput("flush single grant",  32'(grant_log.size()), 32'd1);

    // Read and write together behave as a write
    grant_log.delete(); done_log.delete();
    port_rdata = 32'h5555_AAAA; ack_wait = 1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h180, 32'h0BAD_F00D);
    tick();
    checkOutput("rdwr p_we",    32'(p_we), 32'd1);
    checkOutput("rdwr p_wdata", p_wdata,   32'h0BAD_F00D);
    waitFor("rdwr mem_done", 1, 10, cyc);
    checkOutput("rdwr mem_rdata kept", mem_rdata, 32'hA5A5_0000);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // Reset in the middle of a data access
    grant_log.delete(); done_log.delete();
    ack_wait = 5;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h300, 32'h0);
    tick();
    checkOutput("midrst p_req before", 32'(p_req), 32'd1);
    tick();
    rst = 1'b1;
    #1;
    checkOutput("midrst p_req async", 32'(p_req), 32'd0);
    checkOutput("midrst p_addr",      p_addr,     32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("midrst no done",   32'(done_log.size()), 32'd0);
    checkOutput("midrst p_req",     32'(p_req),           32'd0);
    checkOutput("midrst mem_rdata", mem_rdata,            32'd0);

    // Arbiter accepts a new access after reset
    port_rdata = 32'h7777_0000; ack_wait = 0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h304, 32'h0);
    tick();
    checkOutput("postrst p_req", 32'(p_req), 32'd1);
    tick();
    checkOutput("postrst mem_done",  32'(mem_done), 32'd1);
    checkOutput("postrst mem_rdata", mem_rdata,     32'h7777_0000);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: max consecutive MEM grants while IF waits.
REQ-002 Parameter AW, default 32: address width.
REQ-003 Parameter DW, default 32: data width.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 if_req  in  1  fetch request; held high by IF stage until if_done.
REQ-007 if_addr  in  AW  fetch address (PC).
REQ-008 if_flush  in  1  jump/branch taken; current fetch result is discarded.
REQ-009 if_rdata  out  DW  fetched instruction, registered.
REQ-010 if_done  out  1  one-cycle pulse: if_rdata valid.
REQ-011 mem_rd  in  1  MemRead from the MEM stage; held until mem_done.
REQ-012 mem_wr  in  1  MemWrite from the MEM stage; held until mem_done.
REQ-013 mem_addr  in  AW  data address (ALU result).
REQ-014 mem_wdata  in  DW  store data.
REQ-015 mem_rdata  out  DW  load data, registered.
REQ-016 mem_done  out  1  one-cycle pulse: load data valid or store complete.
REQ-017 stall_if  out  1  freeze PC/IF-ID while the fetch is outstanding.
REQ-018 stall_mem  out  1  freeze the whole pipeline while a data access is outstanding.
REQ-019 p_req  out  1  shared memory port request.
REQ-020 p_we  out  1  port write enable.
REQ-021 p_addr  out  AW  port address.
REQ-022 p_wdata  out  DW  port write data.
REQ-023 p_ack  in  1  port completion; p_rdata valid in the same cycle.
REQ-024 p_rdata  in  DW  port read data.

Function
REQ-025 FSM states are IDLE, BUSY_IF and BUSY_MEM; there is exactly one outstanding port transaction.
REQ-026 IDLE with a MEM request (mem_rd or mem_wr) and starve count < STARVE_LIMIT: the arbiter latches mem_addr, mem_wdata and we=mem_wr, then moves to BUSY_MEM.
REQ-027 IDLE with if_req, no if_flush, and either no MEM request or starve count = STARVE_LIMIT: the arbiter latches if_addr with we=0, then moves to BUSY_IF.
REQ-028 MEM has priority over IF (older instruction); the priority is overridden only by the starvation rule.
REQ-029 Starve counter: increments on each MEM grant while if_req is high; clears on an IF grant or whenever if_req is low; saturates at STARVE_LIMIT.
REQ-030 p_req, p_we, p_addr and p_wdata are registered, driven from the cycle after the grant, and held stable until p_ack is sampled high.
REQ-031 On p_ack, the FSM returns to IDLE, and p_req drops in the next cycle.
REQ-032 On p_ack in BUSY_IF, if_rdata <= p_rdata and if_done pulses in the next cycle, unless the flush rule applies.
REQ-033 On p_ack in BUSY_MEM, mem_rdata <= p_rdata (reads only) and mem_done pulses in the next cycle.
REQ-034 Latency: request at cycle N, p_req at N+1, earliest done at N+2 when p_ack arrives at N+1.
REQ-035 A new grant is decided in IDLE only; the minimum spacing between grants is 2 cycles.
REQ-036 mem_rd and mem_wr both high is illegal; it is treated as a write.
REQ-037 if_flush in BUSY_IF: the port transaction runs to completion, but if_done stays low and if_rdata is unchanged; a flush pending-flag holds this until ack.
REQ-038 if_flush in IDLE blocks an IF grant that cycle only.
REQ-039 stall_if = if_req & ~if_done (combinational).
REQ-040 stall_mem = (mem_rd | mem_wr) & ~mem_done (combinational); stall_mem also forces stall_if high.
REQ-041 p_ack while in IDLE is ignored.

Reset
REQ-042 rst: FSM goes to IDLE; starve count, flush flag, p_req, p_we, if_done and mem_done go to 0; p_addr, p_wdata, if_rdata and mem_rdata go to 0.
REQ-043 rst mid-transaction abandons the port transaction; p_req drops asynchronously, and no done pulse is produced.

Structure
REQ-044 The state encoding (ARB_IDLE, ARB_BUSY_IF, ARB_BUSY_MEM) and the default widths live in the shared package mips_pkg.
REQ-045 The design is flat with no sub-module; the FSM, starve counter and output registers are in one file.

Verification
REQ-046 Lone fetch: if_req=1, if_addr=0x0000_0040, p_ack at the 2nd port cycle with p_rdata=0x8C22_0004 -> p_addr=0x40, p_we=0, if_done one cycle after ack, if_rdata=0x8C22_0004, stall_if low once if_done is seen.
REQ-047 Simultaneous requests: if_req=1 and mem_wr=1, mem_addr=0x100, mem_wdata=0xDEAD_BEEF -> MEM is granted first with p_we=1; IF is granted after mem_done; mem_done precedes if_done.
REQ-048 Starvation: mem_rd held high for 6 back-to-back accesses with if_req=1 and STARVE_LIMIT=4 -> the 5th grant goes to IF.
REQ-049 Flush: if_flush pulsed in BUSY_IF before p_ack -> if_done is never pulsed, if_rdata keeps its old value, and the FSM returns to IDLE after ack.
REQ-050 Reset: rst asserted mid-BUSY_MEM -> p_req=0 immediately, the FSM is in IDLE, and no mem_done pulse follows.
